// File: rtl/level_pkg.sv
// rtl/level_pkg.sv - shared tile codes, map geometry and level-state types
//
// Purpose : common definitions for the platformer level blocks.
// Contents: tile codes, map dimensions, tile_map_t, level_state_e and a
//           small popcount helper used to derive the remaining-coin count.
package level_pkg;

  // Tile codes as stored in the level maps.
  localparam logic [7:0] TILE_BDR = 8'd0;
  localparam logic [7:0] TILE_SKY = 8'd1;
  localparam logic [7:0] TILE_BLK = 8'd2;
  localparam logic [7:0] TILE_GND = 8'd3;
  localparam logic [7:0] TILE_TKN = 8'd4;
  localparam logic [7:0] TILE_CK1 = 8'd5;
  localparam logic [7:0] TILE_CK2 = 8'd6;

  localparam int MAP_ROWS = 12;
  localparam int MAP_COLS = 17;

  // [row][col][byte]; [0][0] is the bottom-right tile on screen.
  typedef logic [MAP_ROWS-1:0][MAP_COLS-1:0][7:0] tile_map_t;

  typedef enum logic [1:0] {
    PLAY = 2'd0,
    WON  = 2'd1,
    LOST = 2'd2
  } level_state_e;

  // Number of set bits in an up-to-8-bit collected mask.
  function automatic logic [3:0] count_ones(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int k = 0; k < 8; k++) begin
      n = n + {3'd0, v[k]};
    end
    return n;
  endfunction

endpackage

// File: rtl/tile_touch.sv
// rtl/tile_touch.sv - combinational Mario-vs-tile bounding-box overlap test
//
// Purpose : reports whether Mario's square bounding box overlaps one map tile.
// Ports   :
//   row, col  in  8   tile coordinates (row 0..11, col 0..16)
//   mario_x   in  32  Mario left edge in pixels (signed)
//   mario_y   in  32  Mario top edge in pixels (signed)
//   touch     out 1   boxes overlap in both axes
module tile_touch
  import level_pkg::*;
#(
  parameter int CHARACTER_WIDTH = 42,
  parameter int BLOCK_WIDTH     = 40
) (
  input  logic        [7:0]  row,
  input  logic        [7:0]  col,
  input  logic signed [31:0] mario_x,
  input  logic signed [31:0] mario_y,
  output logic               touch
);

  logic signed [31:0] w_tile_x;
  logic signed [31:0] w_tile_y;
  logic               w_x_hit;
  logic               w_y_hit;
  logic               w_on_screen;

  // Map index 0 sits at the right/bottom of the screen, so pixel origin
  // counts down from the opposite edge.
  assign w_tile_x = $signed((32'(MAP_COLS) - 32'd1 - 32'(col)) * 32'(BLOCK_WIDTH));
  assign w_tile_y = $signed((32'(MAP_ROWS) - 32'd1 - 32'(row)) * 32'(BLOCK_WIDTH));

  // Strict inequalities: boxes that merely share an edge do not touch.
  assign w_x_hit = (mario_x < w_tile_x + 32'sd0 + $signed(32'(BLOCK_WIDTH))) &&
                   (mario_x + $signed(32'(CHARACTER_WIDTH)) > w_tile_x);
  assign w_y_hit = (mario_y < w_tile_y + $signed(32'(BLOCK_WIDTH))) &&
                   (mario_y + $signed(32'(CHARACTER_WIDTH)) > w_tile_y);

  // A Mario partly off the left/top of the screen never collects anything.
  assign w_on_screen = (mario_x >= 32'sd0) && (mario_y >= 32'sd0);

  assign touch = w_on_screen && w_x_hit && w_y_hit;

endmodule

// File: rtl/level_goal_tracker.sv
// rtl/level_goal_tracker.sv - coin overlay, coin collection, countdown and win/lose resolution
//
// Purpose : overlays coin tiles on the level map, tracks collection, runs the
//           level countdown and resolves the level to WON or LOST.
// Ports   :
//   vga_clock        in   1        sole clock
//   reset            in   1        synchronous, active-high
//   base_background  in   map      level's static tile map
//   mario_x/mario_y  in   32       Mario top-left corner in pixels (signed)
//   background       out  map      registered map with coin overlay
//   coins_remaining  out  4        coins not yet collected
//   seconds          out  8        seconds left on the countdown
//   win / lose       out  1        sticky level outcome flags
module level_goal_tracker
  import level_pkg::*;
#(
  parameter logic [7:0]             BDR               = 8'd0,
  parameter logic [7:0]             SKY               = 8'd1,
  parameter logic [7:0]             TKN               = 8'd4,
  parameter int                     NUM_COINS         = 3,
  parameter logic [8*NUM_COINS-1:0] COIN_COL          = {8'd15, 8'd9, 8'd2},
  parameter logic [8*NUM_COINS-1:0] COIN_ROW          = {8'd3, 8'd2, 8'd5},
  parameter int                     FINISH_X          = 580,
  parameter int                     TIME_LIMIT        = 99,
  parameter int                     CLOCKS_PER_SECOND = 25000000,
  parameter int                     CHARACTER_WIDTH   = 42,
  parameter int                     BLOCK_WIDTH       = 40
) (
  input  logic               vga_clock,
  input  logic               reset,
  input  tile_map_t          base_background,
  input  logic signed [31:0] mario_x,
  input  logic signed [31:0] mario_y,
  output tile_map_t          background,
  output logic        [3:0]  coins_remaining,
  output logic        [7:0]  seconds,
  output logic               win,
  output logic               lose
);

  localparam int PW = (CLOCKS_PER_SECOND > 1) ? $clog2(CLOCKS_PER_SECOND) : 1;
  localparam logic [PW-1:0] PRESCALE_LAST = PW'(CLOCKS_PER_SECOND - 1);

  // Parameter sanity: a bad coin table would silently corrupt the map.
  generate
    if (NUM_COINS < 1 || NUM_COINS > 8) begin : g_bad_num_coins
      $error("level_goal_tracker: NUM_COINS must be 1..8");
    end
    if (TIME_LIMIT < 1 || TIME_LIMIT > 255) begin : g_bad_time_limit
      $error("level_goal_tracker: TIME_LIMIT must be 1..255");
    end
    if (CLOCKS_PER_SECOND < 1) begin : g_bad_cps
      $error("level_goal_tracker: CLOCKS_PER_SECOND must be positive");
    end
    if (TKN == SKY || TKN == BDR) begin : g_bad_tiles
      $error("level_goal_tracker: coin tile code must differ from SKY and BDR");
    end
    for (genvar gi = 0; gi < NUM_COINS; gi++) begin : g_coin_range
      if (COIN_ROW[8*gi +: 8] >= MAP_ROWS || COIN_COL[8*gi +: 8] >= MAP_COLS) begin : g_bad_coin
        $error("level_goal_tracker: coin position outside the tile map");
      end
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  level_state_e          r_state;
  logic [NUM_COINS-1:0]  r_collected;
  logic [3:0]            r_coins_remaining;
  logic [PW-1:0]         r_prescaler;
  logic [7:0]            r_seconds;
  tile_map_t             r_background;

  // ---------------------------------------------------------------------
  // Combinational next values
  // ---------------------------------------------------------------------
  level_state_e          w_state_next;
  logic [NUM_COINS-1:0]  w_touch;
  logic [NUM_COINS-1:0]  w_collected_next;
  logic [3:0]            w_coins_next;
  logic [PW-1:0]         w_prescaler_next;
  logic [7:0]            w_seconds_next;
  tile_map_t             w_background_next;
  logic                  w_at_finish;

  // One overlap checker per coin.
  generate
    for (genvar gi = 0; gi < NUM_COINS; gi++) begin : g_touch
      tile_touch #(
        .CHARACTER_WIDTH (CHARACTER_WIDTH),
        .BLOCK_WIDTH     (BLOCK_WIDTH)
      ) u_tile_touch (
        .row     (COIN_ROW[8*gi +: 8]),
        .col     (COIN_COL[8*gi +: 8]),
        .mario_x (mario_x),
        .mario_y (mario_y),
        .touch   (w_touch[gi])
      );
    end
  endgenerate

  // Collection only happens while playing; collected bits are sticky.
  always_comb begin
    w_collected_next = r_collected;
    if (reset) begin
      w_collected_next = '0;
    end else if (r_state == PLAY) begin
      w_collected_next = r_collected | w_touch;
    end
  end

  // Count and overlay both use the next collected mask so the tile and the
  // count change on the same edge.
  assign w_coins_next = 4'(NUM_COINS) - count_ones(8'(w_collected_next));

  always_comb begin
    w_background_next = base_background;
    for (int i = 0; i < NUM_COINS; i++) begin
      w_background_next[4'(COIN_ROW[8*i +: 8])][5'(COIN_COL[8*i +: 8])] =
        w_collected_next[i] ? SKY : TKN;
    end
  end

  // Countdown: runs only in PLAY, seconds saturates at zero.
  always_comb begin
    w_prescaler_next = r_prescaler;
    w_seconds_next   = r_seconds;
    if (reset) begin
      w_prescaler_next = '0;
      w_seconds_next   = 8'(TIME_LIMIT);
    end else if (r_state == PLAY) begin
      if (r_prescaler == PRESCALE_LAST) begin
        w_prescaler_next = '0;
        w_seconds_next   = (r_seconds == 8'd0) ? 8'd0 : r_seconds - 8'd1;
      end else begin
        w_prescaler_next = r_prescaler + 1'b1;
      end
    end
  end

  always_ff @(posedge vga_clock) begin
    r_collected       <= w_collected_next;
    r_coins_remaining <= w_coins_next;
    r_prescaler       <= w_prescaler_next;
    r_seconds         <= w_seconds_next;
    r_background      <= w_background_next;
  end

  // ---------------------------------------------------------------------
  // Level FSM: state register / next state / outputs
  // ---------------------------------------------------------------------
  always_ff @(posedge vga_clock) begin
    if (reset) begin
      r_state <= PLAY;
    end else begin
      r_state <= w_state_next;
    end
  end

  assign w_at_finish = (mario_x >= $signed(32'(FINISH_X)));

  // Decisions use the registered count and seconds, so the outcome lags the
  // final coin or final tick by one cycle. Winning has priority.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      PLAY: begin
        if (r_coins_remaining == 4'd0 && w_at_finish) begin
          w_state_next = WON;
        end else if (r_seconds == 8'd0) begin
          w_state_next = LOST;
        end
      end
      WON:     w_state_next = WON;
      LOST:    w_state_next = LOST;
      default: w_state_next = PLAY;
    endcase
  end

  always_comb begin
    win  = 1'b0;
    lose = 1'b0;
    case (r_state)
      WON:     win  = 1'b1;
      LOST:    lose = 1'b1;
      default: begin
        win  = 1'b0;
        lose = 1'b0;
      end
    endcase
  end

  assign background      = r_background;
  assign coins_remaining = r_coins_remaining;
  assign seconds         = r_seconds;

endmodule

// File: tb/tb_level_goal_tracker.sv
// tb/tb_level_goal_tracker.sv - self-checking bench for level_goal_tracker
module tb_level_goal_tracker;
  import level_pkg::*;

  localparam int CPS = 4;
  localparam int TL  = 5;
  localparam int NC  = 3;
  localparam int FX  = 580;
  localparam int CW  = 42;
  localparam int BW  = 40;

  logic               vga_clock = 1'b0;
  logic               reset;
  tile_map_t          base_background;
  logic signed [31:0] mario_x;
  logic signed [31:0] mario_y;
  tile_map_t          background;
  logic        [3:0]  coins_remaining;
  logic        [7:0]  seconds;
  logic               win;
  logic               lose;

  always #5 vga_clock = ~vga_clock;

  level_goal_tracker #(
    .CLOCKS_PER_SECOND (CPS),
    .TIME_LIMIT        (TL)
  ) dut (
    .vga_clock       (vga_clock),
    .reset           (reset),
    .base_background (base_background),
    .mario_x         (mario_x),
    .mario_y         (mario_y),
    .background      (background),
    .coins_remaining (coins_remaining),
    .seconds         (seconds),
    .win             (win),
    .lose            (lose)
  );

  // Coin table in the bench's own terms: coin i at (c_row[i], c_col[i]).
  int c_row[NC] = '{5, 2, 3};
  int c_col[NC] = '{2, 9, 15};

  // Reference model state.
  bit        m_coll[NC];
  bit        m_won, m_lost;
  int        m_ticks;      // cycles spent playing inside the current second
  int        m_sec, m_rem;
  tile_map_t m_bg;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Mario box [x,x+CW) x [y,y+CW) against the coin's tile box.
  function automatic bit touches(input int i, input int x, input int y);
    int tx, ty;
    if (x < 0 || y < 0) return 1'b0;
    tx = (16 - c_col[i]) * BW;
    ty = (11 - c_row[i]) * BW;
    return (x < tx + BW) && (x + CW > tx) && (y < ty + BW) && (y + CW > ty);
  endfunction

  task automatic model_edge(input bit rst, input int x, input int y);
    bit go_won, go_lost;
    int got;
    if (rst) begin
      foreach (m_coll[i]) m_coll[i] = 1'b0;
      m_won = 0; m_lost = 0; m_ticks = 0; m_sec = TL;
    end else if (!m_won && !m_lost) begin
      go_won  = (m_rem == 0) && (x >= FX);
      go_lost = (m_sec == 0);
      foreach (m_coll[i]) if (touches(i, x, y)) m_coll[i] = 1'b1;
      m_ticks++;
      if (m_ticks == CPS) begin
        m_ticks = 0;
        if (m_sec > 0) m_sec--;
      end
      if (go_won) m_won = 1;
      else if (go_lost) m_lost = 1;
    end
    got = 0;
    foreach (m_coll[i]) got += int'(m_coll[i]);
    m_rem = NC - got;
    m_bg = base_background;
    foreach (m_coll[i]) m_bg[c_row[i]][c_col[i]] = m_coll[i] ? 8'd1 : 8'd4;
  endtask

  task automatic check_all();
    int r, c;
    check("coins_remaining", coins_remaining, m_rem);
    check("seconds", seconds, m_sec);
    check("win", win, m_won);
    check("lose", lose, m_lost);
    for (int i = 0; i < NC; i++)
      check("coin_tile", background[c_row[i]][c_col[i]], m_bg[c_row[i]][c_col[i]]);
    r = $urandom_range(0, 11);
    c = $urandom_range(0, 16);
    check("map_cell", background[r][c], m_bg[r][c]);
  endtask

  task automatic cycle(input bit rst, input int x, input int y);
    reset   = rst;
    mario_x = x;
    mario_y = y;
    @(posedge vga_clock);
    model_edge(rst, x, y);
    #1;
    check_all();
  endtask

  int exp_sec;

  initial begin
    reset = 1'b1;
    mario_x = 300;
    mario_y = 400;
    for (int r = 0; r < 12; r++)
      for (int c = 0; c < 17; c++)
        base_background[r][c] = 8'($urandom_range(0, 6));
    m_rem = NC;
    m_sec = TL;

    // Reset state.
    cycle(1, 300, 400);
    cycle(1, 300, 400);
    check("rst_tile_3_15", background[3][15], 4);
    check("rst_tile_2_9", background[2][9], 4);
    check("rst_tile_5_2", background[5][2], 4);
    check("rst_coins", coins_remaining, 3);
    check("rst_seconds", seconds, 5);
    check("rst_win", win, 0);
    check("rst_lose", lose, 0);

    // First coin, then hold position.
    cycle(0, 40, 320);
    check("coin_a_tile", background[3][15], 1);
    check("coin_a_count", coins_remaining, 2);
    for (int k = 0; k < 3; k++) cycle(0, 40, 320);
    check("coin_a_hold", coins_remaining, 2);

    // Second coin, then finish line with one coin left.
    cycle(0, 280, 360);
    check("coin_b_count", coins_remaining, 1);
    cycle(0, 600, 400);
    cycle(0, 600, 400);
    check("finish_early_win", win, 0);

    // Last coin at the finish line, then hold x=600.
    cycle(0, 580, 240);
    check("last_coin_count", coins_remaining, 0);
    check("last_coin_no_win_yet", win, 0);
    cycle(0, 600, 400);
    check("won", win, 1);
    for (int k = 0; k < 10; k++) cycle(0, 600, 400);
    check("won_sticky", win, 1);
    check("won_seconds_frozen", seconds, 3);

    // Timeout with no touches.
    cycle(1, 300, 400);
    for (int k = 1; k <= 25; k++) begin
      cycle(0, 300, 400);
      exp_sec = TL - k / CPS;
      if (exp_sec < 0) exp_sec = 0;
      check("countdown", seconds, exp_sec);
      check("lose_timing", lose, (k >= 21) ? 1 : 0);
    end

    // Reset out of LOST.
    cycle(1, 300, 400);
    check("lost_rst_lose", lose, 0);
    check("lost_rst_seconds", seconds, 5);
    check("lost_rst_tile", background[3][15], 4);
    check("lost_rst_coins", coins_remaining, 3);

    // Last coin collected on the edge where seconds reaches zero.
    cycle(0, 40, 320);
    cycle(0, 280, 360);
    for (int k = 3; k <= 19; k++) cycle(0, 300, 400);
    cycle(0, 580, 240);
    check("race_seconds", seconds, 0);
    check("race_coins", coins_remaining, 0);
    cycle(0, 600, 400);
    check("race_win", win, 1);
    check("race_lose", lose, 0);

    // Randomized play with map churn and occasional resets.
    cycle(1, 300, 400);
    for (int k = 0; k < 600; k++) begin
      int x, y, ci;
      if ($urandom_range(0, 3) != 0) begin
        ci = $urandom_range(0, NC - 1);
        x = (16 - c_col[ci]) * BW + $urandom_range(0, 100) - 50;
        y = (11 - c_row[ci]) * BW + $urandom_range(0, 100) - 50;
      end else begin
        x = $urandom_range(0, 740) - 40;
        y = $urandom_range(0, 520) - 40;
      end
      if ($urandom_range(0, 2) == 0)
        base_background[$urandom_range(0, 11)][$urandom_range(0, 16)] = 8'($urandom);
      cycle(($urandom_range(0, 59) == 0) ? 1'b1 : 1'b0, x, y);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
